regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//   Parametrised register file: two combinational read ports, one synchronous write port.
//   One entry can be mapped to an external input, and entry 0 is exported as a live output.
//   A sequential clear engine zeroes all stored entries, one per cycle, on request.
//   Sits between the datapath ALU and the decode stage of the next-generation core.
// PARAMETERS
//   WIDTH    4  data width of every entry
//   DEPTH    8  number of addressable entries, >=2; need not be a power of 2
//   EXT_IDX  1  entry backed by EXT_DATA instead of storage; any value >=DEPTH means none
//   AW       $clog2(DEPTH)  localparam, address width
// PORTS
//   CLK       in   1      clock
//   RSTN      in   1      reset, synchronous, active-low
//   WEN       in   1      write enable
//   WADDR     in   AW     write address
//   WDATA     in   WIDTH  write data
//   RADDR0    in   AW     read address, port 0
//   RDATA0    out  WIDTH  read data, port 0 (combinational)
//   RADDR1    in   AW     read address, port 1
//   RDATA1    out  WIDTH  read data, port 1 (combinational)
//   EXT_DATA  in   WIDTH  value returned for reads of EXT_IDX
//   R0DATA    out  WIDTH  live contents of entry 0
//   CLR_REQ   in   1      single-cycle clear request
//   BUSY      out  1      clear engine active
//   CLR_DONE  out  1      one-cycle pulse on the cycle after the last entry is cleared
//   WDROP     out  1      one-cycle pulse when a WEN is discarded
// BEHAVIOUR
//   Reset (RSTN=0 at posedge):
//     - all stored entries = 0; FSM = IDLE.
//     - BUSY, CLR_DONE and WDROP = 0.
//     - R0DATA = 0 (or EXT_DATA if EXT_IDX = 0).
//   Reads: RDATA = EXT_DATA if RADDR==EXT_IDX; the stored entry if RADDR<DEPTH; 0 otherwise.
//   Writes in IDLE:
//     - WEN=1 and WADDR<DEPTH and WADDR!=EXT_IDX -> entry updated at the posedge (1-cycle latency).
//     - Write to EXT_IDX or an out-of-range address -> ignored, WDROP=1 next cycle.
//   FSM IDLE:
//     - CLR_REQ=1 -> CLEAR next cycle, clear counter=0, BUSY=1.
//     - A WEN in the same cycle is still performed; the clear later overwrites it.
//   FSM CLEAR:
//     - Each cycle: entry[counter] <= 0 (EXT_IDX is skipped but still costs one cycle); counter++.
//     - After the counter reaches DEPTH-1: -> IDLE, BUSY=0, CLR_DONE=1 for one cycle.
//     - Total BUSY time is exactly DEPTH cycles.
//     - WEN during CLEAR -> write discarded, WDROP=1 next cycle.
//     - CLR_REQ during CLEAR is ignored (no restart).
//     - Reads during CLEAR return current contents (some entries already cleared).
//   Reset mid-clear: immediate return to IDLE, all entries 0, no CLR_DONE pulse.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - Read forwarding. If a read address equals an accepted WADDR in the same cycle, RDATA = WDATA combinationally.
//     - Forwarding is not applied to a write that WDROP flags.
//     - R0DATA also forwards when WADDR==0.
//   REGFILE_BYPASS_EN undefined: reads return the pre-write value until the next cycle.
// STRUCTURE
//   Package regfile_pkg:
//     - FSM state enum (IDLE, CLEAR).
//     - Default WIDTH/DEPTH constants.
//     - Address-width function.
//   Sub-module regfile_wsel: binary-to-one-hot write-select decoder with enable and range check.
//     - Instantiated once.
//     - Its in-range flag drives WDROP.
//   The FSM, clear counter and read muxes live in this module.
// TESTING
//   Reset, then read all 8 addresses with EXT_DATA=4'hA -> 0 everywhere except addr 1 = 4'hA; R0DATA=0.
//   Write 4'h5 to addr 3, read on the next cycle via both ports -> 4'h5 on both.
//     - Same cycle without the macro -> old value; with REGFILE_BYPASS_EN -> 4'h5.
//   Write to addr 1 -> entry unchanged, WDROP=1 for one cycle.
//     - Repeat with DEPTH=6, addr 7 -> RDATA=0, WDROP=1.
//   Fill all entries with 4'hF, pulse CLR_REQ:
//     - BUSY=1 for exactly 8 cycles, then CLR_DONE pulses once.
//     - Afterwards every stored entry reads 0.
//   During CLEAR: issue WEN to addr 7 -> WDROP=1 and entry 7 ends at 0.
//     - Pulse CLR_REQ again mid-clear -> BUSY length is unchanged.
//   Assert RSTN=0 mid-clear -> BUSY=0, no CLR_DONE, all entries 0.
//     - A new CLR_REQ afterwards runs a full 8-cycle clear.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read/1-write register file: clear-engine
// state encoding, default geometry and the address-width helper.
// Optional feature macro used by the top level: REGFILE_BYPASS_EN.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam int DEF_WIDTH   = 4;
   localparam int DEF_DEPTH   = 8;
   localparam int DEF_EXT_IDX = 1;

   // Address width for a given number of entries; never narrower than one bit.
   function automatic int addr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_wsel.sv
// Write-select decoder: turns a binary write address into a one-hot entry
// select. An address is a legal write target only when it is inside the
// array and is not the entry backed by the external input.
module regfile_wsel
   import regfile_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int EXT_IDX = DEF_EXT_IDX,
   parameter int AW      = addr_width(DEF_DEPTH)
) (
   input  logic             en,
   input  logic [AW-1:0]    addr,
   output logic [DEPTH-1:0] sel,
   output logic             in_range
);

   assign in_range = (int'(addr) < DEPTH) && (int'(addr) != EXT_IDX);

   // One-hot select, only asserted for an enabled write to a legal entry.
   always_comb begin
      sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         sel[i] = en && in_range && (int'(addr) == i);
      end
   end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports and one synchronous write
// port. One entry (EXT_IDX) reads the EXT_DATA input instead of storage, and
// entry 0 is exported live on R0DATA. A clear engine zeroes one entry per
// cycle for DEPTH cycles after CLR_REQ; writes arriving during a clear are
// dropped and flagged on WDROP.
// Optional feature: define REGFILE_BYPASS_EN to forward an accepted write's
// data to reads of the same address in the same cycle.
//
// Handshake note: there is no backpressure. WEN is a one-cycle request that is
// either performed at the next posedge or discarded, in which case WDROP
// pulses on the following cycle. CLR_REQ is only sampled while BUSY is low.
module regfile_2r1w
   import regfile_pkg::*;
#(
   parameter int   WIDTH   = DEF_WIDTH,
   parameter int   DEPTH   = DEF_DEPTH,
   parameter int   EXT_IDX = DEF_EXT_IDX,
   localparam int  AW      = addr_width(DEPTH)
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             WEN,
   input  logic [AW-1:0]    WADDR,
   input  logic [WIDTH-1:0] WDATA,
   input  logic [AW-1:0]    RADDR0,
   output logic [WIDTH-1:0] RDATA0,
   input  logic [AW-1:0]    RADDR1,
   output logic [WIDTH-1:0] RDATA1,
   input  logic [WIDTH-1:0] EXT_DATA,
   output logic [WIDTH-1:0] R0DATA,
   input  logic             CLR_REQ,
   output logic             BUSY,
   output logic             CLR_DONE,
   output logic             WDROP
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t             state;
   state_t             state_nxt;
   logic [AW-1:0]      cnt;
   logic [AW-1:0]      cnt_nxt;
   logic               done_nxt;

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [DEPTH-1:0]   sel;
   logic               in_range;
   logic               wr_idle;
   logic               accept;
   logic               drop;

   // Writes are only eligible while the clear engine is idle.
   assign wr_idle = WEN && (state == IDLE);
   assign accept  = wr_idle && in_range;
   assign drop    = WEN && !accept;
   assign BUSY    = (state == CLEAR);

   regfile_wsel #(
      .DEPTH   (DEPTH),
      .EXT_IDX (EXT_IDX),
      .AW      (AW)
   ) u_wsel (
      .en       (wr_idle),
      .addr     (WADDR),
      .sel      (sel),
      .in_range (in_range)
   );

   // Clear-engine next state: start on request, walk every index, then finish.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (CLR_REQ) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            if (cnt == LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + AW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Clear-engine state, counter and the one-cycle status pulses.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state    <= IDLE;
         cnt      <= '0;
         CLR_DONE <= 1'b0;
         WDROP    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         CLR_DONE <= done_nxt;
         WDROP    <= drop;
      end
   end

   // Storage: the clear engine zeroes the indexed entry, otherwise accept writes.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if ((state == CLEAR) && (int'(cnt) == i)) begin
               mem[i] <= '0;
            end else if (sel[i]) begin
               mem[i] <= WDATA;
            end
         end
      end
   end

   // Read port 0: storage, optional same-cycle forwarding, external entry on top.
   always_comb begin
      RDATA0 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (int'(RADDR0) == i) begin
            RDATA0 = mem[i];
         end
      end
`ifdef REGFILE_BYPASS_EN
      if (accept && (RADDR0 == WADDR)) begin
         RDATA0 = WDATA;
      end
`endif
      if (int'(RADDR0) == EXT_IDX) begin
         RDATA0 = EXT_DATA;
      end
   end

   // Read port 1: same selection rules as port 0.
   always_comb begin
      RDATA1 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (int'(RADDR1) == i) begin
            RDATA1 = mem[i];
         end
      end
`ifdef REGFILE_BYPASS_EN
      if (accept && (RADDR1 == WADDR)) begin
         RDATA1 = WDATA;
      end
`endif
      if (int'(RADDR1) == EXT_IDX) begin
         RDATA1 = EXT_DATA;
      end
   end

   // Live view of entry 0, following the same forwarding and external rules.
   always_comb begin
      R0DATA = mem[0];
`ifdef REGFILE_BYPASS_EN
      if (accept && (WADDR == '0)) begin
         R0DATA = WDATA;
      end
`endif
      if (EXT_IDX == 0) begin
         R0DATA = EXT_DATA;
      end
   end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: a behavioural model of the register file is updated
// on every posedge and compared against all outputs on every negedge, with
// directed sequences that pin literal values, followed by a random phase.
module tb_regfile_2r1w;

   localparam int W   = 4;
   localparam int D   = 8;
   localparam int EXT = 1;

   logic         clk;
   logic         rstn;
   logic         wen;
   logic [2:0]   waddr;
   logic [W-1:0] wdata;
   logic [2:0]   raddr0;
   logic [W-1:0] rdata0;
   logic [2:0]   raddr1;
   logic [W-1:0] rdata1;
   logic [W-1:0] ext_data;
   logic [W-1:0] r0data;
   logic         clr_req;
   logic         busy;
   logic         clr_done;
   logic         wdrop;

   // second instance with a non power-of-two depth
   logic         wen6;
   logic [2:0]   waddr6;
   logic [W-1:0] wdata6;
   logic [2:0]   raddr6;
   logic [W-1:0] rdata6_0;
   logic [W-1:0] rdata6_1;
   logic [W-1:0] r0data6;
   logic         busy6;
   logic         done6;
   logic         wdrop6;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   regfile_2r1w #(.WIDTH(W), .DEPTH(D), .EXT_IDX(EXT)) u_dut (
      .CLK(clk), .RSTN(rstn), .WEN(wen), .WADDR(waddr), .WDATA(wdata),
      .RADDR0(raddr0), .RDATA0(rdata0), .RADDR1(raddr1), .RDATA1(rdata1),
      .EXT_DATA(ext_data), .R0DATA(r0data), .CLR_REQ(clr_req), .BUSY(busy),
      .CLR_DONE(clr_done), .WDROP(wdrop)
   );

   regfile_2r1w #(.WIDTH(W), .DEPTH(6), .EXT_IDX(EXT)) u_dut6 (
      .CLK(clk), .RSTN(rstn), .WEN(wen6), .WADDR(waddr6), .WDATA(wdata6),
      .RADDR0(raddr6), .RDATA0(rdata6_0), .RADDR1(raddr6), .RDATA1(rdata6_1),
      .EXT_DATA(ext_data), .R0DATA(r0data6), .CLR_REQ(1'b0), .BUSY(busy6),
      .CLR_DONE(done6), .WDROP(wdrop6)
   );

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_mem [D];
   int           m_clr_left = 0;   // clear cycles still to run, 0 when idle
   logic         m_done = 1'b0;
   logic         m_drop = 1'b0;
   bit           m_valid = 1'b0;
   bit           acc;

   function automatic bit accepted_now();
      return wen && (m_clr_left == 0) && (int'(waddr) < D) && (int'(waddr) != EXT);
   endfunction

   function automatic logic [W-1:0] exp_read(input logic [2:0] a);
      if (int'(a) == EXT) return ext_data;
      if (int'(a) >= D) return '0;
`ifdef REGFILE_BYPASS_EN
      if (accepted_now() && (waddr == a)) return wdata;
`endif
      return m_mem[a];
   endfunction

   always @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < D; i++) m_mem[i] = '0;
         m_clr_left = 0;
         m_done     = 1'b0;
         m_drop     = 1'b0;
         m_valid    = 1'b1;
      end else if (m_valid) begin
         acc    = accepted_now();
         m_drop = wen && !acc;
         m_done = 1'b0;
         if (acc) m_mem[waddr] = wdata;
         if (m_clr_left > 0) begin
            m_mem[D - m_clr_left] = '0;
            m_clr_left--;
            if (m_clr_left == 0) m_done = 1'b1;
         end else if (clr_req) begin
            m_clr_left = D;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_rdata0", 32'(rdata0), 32'(exp_read(raddr0)));
         check("model_rdata1", 32'(rdata1), 32'(exp_read(raddr1)));
         check("model_r0data", 32'(r0data), 32'(exp_read(3'd0)));
         check("model_busy", 32'(busy), 32'(m_clr_left > 0));
         check("model_clr_done", 32'(clr_done), 32'(m_done));
         check("model_wdrop", 32'(wdrop), 32'(m_drop));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic fill(input logic [W-1:0] v);
      for (int a = 0; a < D; a++) begin
         wen = 1'b1; waddr = 3'(a); wdata = v;
         cyc();
      end
      wen = 1'b0;
   endtask

   // every entry reads 0 except the external one
   task automatic read_all_zero(input string name);
      logic [W-1:0] e0;
      logic [W-1:0] e1;
      for (int a = 0; a < D; a++) begin
         raddr0 = 3'(a); raddr1 = 3'(D - 1 - a);
         e0 = (a == EXT) ? ext_data : '0;
         e1 = ((D - 1 - a) == EXT) ? ext_data : '0;
         mid();
         check({name, "_p0"}, 32'(rdata0), 32'(e0));
         check({name, "_p1"}, 32'(rdata1), 32'(e1));
         cyc();
      end
   endtask

   // pulse CLR_REQ and observe 20 cycles; optional drop-write, re-request, reset
   task automatic run_clear(input bit wen7, input bit reclr, input int rst_at,
                            output int busy_n, output int done_n);
      clr_req = 1'b1;
      cyc();
      clr_req = 1'b0;
      busy_n = 0;
      done_n = 0;
      for (int k = 0; k < 20; k++) begin
         wen     = wen7 && (k == 1);
         waddr   = 3'd7;
         wdata   = 4'hF;
         clr_req = reclr && (k == 3);
         rstn    = !(k == rst_at);
         mid();
         busy_n += int'(busy);
         done_n += int'(clr_done);
         cyc();
      end
      wen = 1'b0; clr_req = 1'b0; rstn = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   int bn;
   int dn;

   initial begin
      rstn = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; raddr0 = '0; raddr1 = '0;
      ext_data = 4'hA; clr_req = 1'b0;
      wen6 = 1'b0; waddr6 = '0; wdata6 = '0; raddr6 = '0;
      cyc(); cyc();
      mid();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_r0data", 32'(r0data), 32'd0);
      rstn = 1'b1;
      cyc();

      read_all_zero("reset_read");

      // write 5 to entry 3, observe same cycle and next cycle
      wen = 1'b1; waddr = 3'd3; wdata = 4'h5; raddr0 = 3'd3; raddr1 = 3'd3;
      mid();
`ifdef REGFILE_BYPASS_EN
      check("same_cycle_read", 32'(rdata0), 32'h5);
`else
      check("same_cycle_read", 32'(rdata0), 32'h0);
`endif
      cyc();
      wen = 1'b0;
      mid();
      check("write3_p0", 32'(rdata0), 32'h5);
      check("write3_p1", 32'(rdata1), 32'h5);
      cyc();

      // write to the external entry is dropped
      wen = 1'b1; waddr = 3'd1; wdata = 4'h7; raddr0 = 3'd1;
      cyc();
      wen = 1'b0;
      mid();
      check("ext_write_wdrop", 32'(wdrop), 32'd1);
      check("ext_write_unchanged", 32'(rdata0), 32'hA);
      cyc();
      mid();
      check("ext_write_wdrop_once", 32'(wdrop), 32'd0);
      cyc();

      // DEPTH=6 instance: out-of-range address
      wen6 = 1'b1; waddr6 = 3'd7; wdata6 = 4'h3; raddr6 = 3'd7;
      mid();
      check("d6_oob_read", 32'(rdata6_0), 32'd0);
      cyc();
      wen6 = 1'b0;
      mid();
      check("d6_oob_wdrop", 32'(wdrop6), 32'd1);
      check("d6_oob_read_after", 32'(rdata6_1), 32'd0);
      cyc();

      // full clear
      fill(4'hF);
      raddr0 = 3'd0;
      mid();
      check("filled_r0data", 32'(r0data), 32'hF);
      cyc();
      run_clear(1'b0, 1'b0, -1, bn, dn);
      check("clear_busy_len", 32'(bn), 32'd8);
      check("clear_done_cnt", 32'(dn), 32'd1);
      read_all_zero("after_clear");

      // clear with a dropped write to 7 and a second request mid-clear
      fill(4'hF);
      run_clear(1'b1, 1'b1, -1, bn, dn);
      check("clear2_busy_len", 32'(bn), 32'd8);
      check("clear2_done_cnt", 32'(dn), 32'd1);
      raddr0 = 3'd7;
      mid();
      check("clear2_entry7", 32'(rdata0), 32'd0);
      cyc();

      // reset in the middle of a clear
      fill(4'hF);
      run_clear(1'b0, 1'b0, 3, bn, dn);
      check("rst_clear_busy_len", 32'(bn), 32'd4);
      check("rst_clear_done_cnt", 32'(dn), 32'd0);
      mid();
      check("rst_clear_busy", 32'(busy), 32'd0);
      cyc();
      read_all_zero("after_rst_clear");
      run_clear(1'b0, 1'b0, -1, bn, dn);
      check("clear3_busy_len", 32'(bn), 32'd8);
      check("clear3_done_cnt", 32'(dn), 32'd1);

      // random phase, checked against the model every cycle
      for (int n = 0; n < 600; n++) begin
         wen      = 1'($urandom_range(0, 1));
         waddr    = 3'($urandom_range(0, 7));
         wdata    = 4'($urandom_range(0, 15));
         raddr0   = 3'($urandom_range(0, 7));
         raddr1   = 3'($urandom_range(0, 7));
         ext_data = 4'($urandom_range(0, 15));
         clr_req  = ($urandom_range(0, 24) == 0);
         rstn     = ($urandom_range(0, 149) != 0);
         cyc();
      end
      rstn = 1'b1; wen = 1'b0; clr_req = 1'b0;
      for (int n = 0; n < 12; n++) cyc();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
